// File: rtl/sobel_edge_detect_3x3.sv
// Sobel |Gx|+|Gy| over a 3x3 window stream, 3-clk pipeline with saturated magnitude and thresholded edge bit.
// Optional border masking of the first two lines/columns is enabled by defining SOBEL_BORDER_MASK_EN.
module sobel_edge_detect_3x3 #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_HDISP  = 640,
    parameter int IMG_VDISP  = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  matrix_frame_vsync,
    input  logic                  matrix_frame_href,
    input  logic [DATA_WIDTH-1:0] matrix_p11,
    input  logic [DATA_WIDTH-1:0] matrix_p12,
    input  logic [DATA_WIDTH-1:0] matrix_p13,
    input  logic [DATA_WIDTH-1:0] matrix_p21,
    input  logic [DATA_WIDTH-1:0] matrix_p22,
    input  logic [DATA_WIDTH-1:0] matrix_p23,
    input  logic [DATA_WIDTH-1:0] matrix_p31,
    input  logic [DATA_WIDTH-1:0] matrix_p32,
    input  logic [DATA_WIDTH-1:0] matrix_p33,
    input  logic [DATA_WIDTH-1:0] threshold,
    output logic                  post_frame_vsync,
    output logic                  post_frame_href,
    output logic [DATA_WIDTH-1:0] post_img_Data,
    output logic                  post_img_Bit
);

    localparam int SW = DATA_WIDTH + 2;

    if (IMG_HDISP < 4 || IMG_VDISP < 4) begin : g_bad_geometry
        $error("sobel_edge_detect_3x3: IMG_HDISP and IMG_VDISP must be at least 4");
    end

    logic [SW-1:0] gx_p, gx_n, gy_p, gy_n;
    logic [SW-1:0] gx, gy;
    logic [SW:0]   g;
    logic [2:0]    vsync_d, href_d;
    logic          gate;

    // Stage 1: weighted column/row sums
    always_ff @(posedge clk) begin
        if (rst) begin
            gx_p <= '0;
            gx_n <= '0;
            gy_p <= '0;
            gy_n <= '0;
        end else begin
            gx_p <= SW'(matrix_p13) + (SW'(matrix_p23) << 1) + SW'(matrix_p33);
            gx_n <= SW'(matrix_p11) + (SW'(matrix_p21) << 1) + SW'(matrix_p31);
            gy_p <= SW'(matrix_p11) + (SW'(matrix_p12) << 1) + SW'(matrix_p13);
            gy_n <= SW'(matrix_p31) + (SW'(matrix_p32) << 1) + SW'(matrix_p33);
        end
    end

    // Stage 2: absolute differences as larger minus smaller
    always_ff @(posedge clk) begin
        if (rst) begin
            gx <= '0;
            gy <= '0;
        end else begin
            gx <= (gx_p >= gx_n) ? (gx_p - gx_n) : (gx_n - gx_p);
            gy <= (gy_p >= gy_n) ? (gy_p - gy_n) : (gy_n - gy_p);
        end
    end

    always_comb begin
        g = {1'b0, gx} + {1'b0, gy};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d <= '0;
            href_d  <= '0;
        end else begin
            vsync_d <= {vsync_d[1:0], matrix_frame_vsync};
            href_d  <= {href_d[1:0], matrix_frame_href};
        end
    end

    assign post_frame_vsync = vsync_d[2];
    assign post_frame_href  = href_d[2];

`ifdef SOBEL_BORDER_MASK_EN
    localparam int HW = $clog2(IMG_HDISP);
    localparam int VW = $clog2(IMG_VDISP);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          mask_in;
    logic [1:0]    mask_d;

    // href_d[0]/vsync_d[0] are the previous-cycle inputs, reused for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt   <= '0;
            vcnt   <= '0;
            mask_d <= '0;
        end else begin
            if (!matrix_frame_href)
                hcnt <= '0;
            else if (hcnt < HW'(IMG_HDISP - 1))
                hcnt <= hcnt + HW'(1);

            if (matrix_frame_vsync && !vsync_d[0])
                vcnt <= '0;
            else if (!matrix_frame_href && href_d[0] && vcnt < VW'(IMG_VDISP - 1))
                vcnt <= vcnt + VW'(1);

            mask_d <= {mask_d[0], mask_in};
        end
    end

    always_comb begin
        mask_in = (hcnt < HW'(2)) || (vcnt < VW'(2));
        gate    = href_d[1] && !mask_d[1];
    end
`else
    always_comb begin
        gate = href_d[1];
    end
`endif

    // Stage 3: saturate, threshold and gate
    always_ff @(posedge clk) begin
        if (rst) begin
            post_img_Data <= '0;
            post_img_Bit  <= 1'b0;
        end else if (gate) begin
            post_img_Data <= (g > (SW+1)'({DATA_WIDTH{1'b1}})) ? '1 : g[DATA_WIDTH-1:0];
            post_img_Bit  <= (g > (SW+1)'(threshold));
        end else begin
            post_img_Data <= '0;
            post_img_Bit  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_edge_detect_3x3.sv
// Self-checking bench for sobel_edge_detect_3x3: directed cases plus random stream against an
// integer-arithmetic reference model; border mask expectations follow SOBEL_BORDER_MASK_EN.
module tb_sobel_edge_detect_3x3;

    localparam int DW = 8;
    localparam int HD = 8;
    localparam int VD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          vsync, href;
    logic [DW-1:0] tap [9];
    logic [DW-1:0] threshold;
    logic          post_frame_vsync, post_frame_href, post_img_Bit;
    logic [DW-1:0] post_img_Data;

    always #5 clk = ~clk;

    sobel_edge_detect_3x3 #(
        .DATA_WIDTH(DW),
        .IMG_HDISP (HD),
        .IMG_VDISP (VD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .matrix_frame_vsync(vsync),
        .matrix_frame_href (href),
        .matrix_p11        (tap[0]),
        .matrix_p12        (tap[1]),
        .matrix_p13        (tap[2]),
        .matrix_p21        (tap[3]),
        .matrix_p22        (tap[4]),
        .matrix_p23        (tap[5]),
        .matrix_p31        (tap[6]),
        .matrix_p32        (tap[7]),
        .matrix_p33        (tap[8]),
        .threshold         (threshold),
        .post_frame_vsync  (post_frame_vsync),
        .post_frame_href   (post_frame_href),
        .post_img_Data     (post_img_Data),
        .post_img_Bit      (post_img_Bit)
    );

    typedef struct {
        bit rst;
        bit vs;
        bit hs;
        bit mask;
        int thr;
        int p [9];
    } samp_t;

    samp_t hist [$];
    int    checks   = 0;
    int    failures = 0;
    int    ones     = 0;
    int    col      = 0;
    int    line     = 0;
    bit    vs_prev  = 1'b0;
    bit    hs_prev  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One clock: record the sampled inputs, then compare outputs against the model
    task automatic tick();
        samp_t s, a;
        int    n, g, e_data;
        bit    zero, pass, e_bit;
        @(posedge clk);
        s.rst = rst;
        s.vs  = vsync;
        s.hs  = href;
        s.thr = int'(threshold);
        for (int i = 0; i < 9; i++) s.p[i] = int'(tap[i]);
`ifdef SOBEL_BORDER_MASK_EN
        s.mask = (col < 2) || (line < 2);
`else
        s.mask = 1'b0;
`endif
        if (rst) begin
            col = 0; line = 0; vs_prev = 1'b0; hs_prev = 1'b0;
        end else begin
            if (vsync && !vs_prev) line = 0;
            else if (!href && hs_prev && line < VD - 1) line++;
            col = href ? ((col < HD - 1) ? col + 1 : col) : 0;
            vs_prev = vsync;
            hs_prev = href;
        end
        hist.push_back(s);
        #1;
        n = hist.size() - 1;
        if (post_img_Bit === 1'b1) ones++;
        if (n >= 2) begin
            a    = hist[n-2];
            zero = hist[n].rst || hist[n-1].rst || a.rst;
            g    = iabs((a.p[2] + 2*a.p[5] + a.p[8]) - (a.p[0] + 2*a.p[3] + a.p[6]))
                 + iabs((a.p[0] + 2*a.p[1] + a.p[2]) - (a.p[6] + 2*a.p[7] + a.p[8]));
            pass   = !zero && a.hs && !a.mask;
            e_data = pass ? ((g > 255) ? 255 : g) : 0;
            e_bit  = pass && (g > hist[n].thr);
            check_eq("data",  32'(post_img_Data),    32'(e_data));
            check_eq("bit",   32'(post_img_Bit),     32'(e_bit));
            check_eq("href",  32'(post_frame_href),  32'(!zero && a.hs));
            check_eq("vsync", 32'(post_frame_vsync), 32'(!zero && a.vs));
        end
    endtask

    task automatic set_taps(input int left, input int mid, input int right);
        for (int r = 0; r < 3; r++) begin
            tap[3*r]   = DW'(left);
            tap[3*r+1] = DW'(mid);
            tap[3*r+2] = DW'(right);
        end
    endtask

    task automatic run_frame(input int exp_ones);
        ones = 0;
        vsync = 1'b1; href = 1'b0;
        tick(); tick();
        vsync = 1'b0;
        tick();
        for (int l = 0; l < VD; l++) begin
            href = 1'b1;
            for (int c = 0; c < HD; c++) tick();
            href = 1'b0;
            for (int c = 0; c < 3; c++) tick();
        end
        tick(); tick(); tick();
        check_eq("frame_ones", 32'(ones), 32'(exp_ones));
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; href = 1'b0; threshold = '0;
        set_taps(0, 0, 0);
        repeat (4) tick();
        rst = 1'b0;

        // Active stream, then reset held for 3 clk mid-stream
        href = 1'b1; set_taps(0, 0, 200); threshold = 8'd5;
        repeat (4) tick();
        rst = 1'b1;
        repeat (3) begin
            tick();
            check_eq("rst_data", 32'(post_img_Data), 32'd0);
        end
        rst = 1'b0;
        repeat (3) tick();

        // Flat window
        set_taps(100, 100, 100); threshold = 8'd10;
        repeat (4) tick();
        check_eq("flat_data", 32'(post_img_Data), 32'd0);

        // Vertical edge saturates
        set_taps(0, 0, 255); threshold = 8'd50;
        repeat (4) tick();
        check_eq("vedge_data", 32'(post_img_Data), 32'd255);

        // Threshold boundary, g = 40
        set_taps(0, 0, 10); threshold = 8'd40;
        repeat (4) tick();
        check_eq("thr40_bit", 32'(post_img_Bit), 32'd0);
        threshold = 8'd39;
        tick();
        check_eq("thr39_bit", 32'(post_img_Bit), 32'd1);

        // href pulse of 5 clk with vsync toggling
        href = 1'b0;
        repeat (3) tick();
        set_taps(0, 0, 255);
        for (int i = 0; i < 12; i++) begin
            href  = (i >= 2 && i < 7);
            vsync = i[0];
            tick();
        end
        vsync = 1'b0; href = 1'b0;
        repeat (3) tick();

        // Two full frames
`ifdef SOBEL_BORDER_MASK_EN
        run_frame(12);
        run_frame(12);
`else
        run_frame(HD * VD);
        run_frame(HD * VD);
`endif

        // Random stream
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            href  = ($urandom_range(0, 3) != 0);
            vsync = ($urandom_range(0, 39) == 0);
            threshold = DW'($urandom);
            for (int k = 0; k < 9; k++)
                tap[k] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 1) * 255) : DW'($urandom);
            tick();
        end
        rst = 1'b0; href = 1'b0; vsync = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
